// File: rtl/irq_arbiter.sv
// Platform-level external interrupt arbiter: per-source gateways, priority/threshold selection,
// claim/complete handshake and a registered meip_out toward mcsr.mip.meip.
module irq_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int PRI_W   = 3,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               cfg_we,
    input  logic [ID_W:0]      cfg_addr,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    input  logic               claim_req,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_req,
    input  logic [ID_W-1:0]    complete_id,
    output logic               meip_out,
    output logic [NUM_SRC-1:0] pending_out
);

    localparam int AW = ID_W + 1;

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

    gw_state_e          gw_q   [NUM_SRC];
    gw_state_e          gw_d   [NUM_SRC];
    logic [PRI_W-1:0]   prio_q [NUM_SRC];
    logic [PRI_W-1:0]   prio_d [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [PRI_W-1:0]   thr_q, thr_d;
    logic [ID_W-1:0]    best_id_q, best_id_d;
    logic               meip_q, meip_d;

    logic [NUM_SRC-1:0] eligible;
    logic [PRI_W-1:0]   best_pri;

    // Strict '>' on the running best keeps the lowest ID on priority ties.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        eligible  = '0;
        best_pri  = '0;
        best_id_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = (gw_q[i] == GW_PENDING) && enable_q[i] && (prio_q[i] > thr_q);
            if (eligible[i] && (prio_q[i] > best_pri)) begin
                best_pri  = prio_q[i];
                best_id_d = ID_W'(i + 1);
            end
        end
        meip_d = (best_id_d != '0);
    end

    // Claims grant the registered winner, so a source that pends this cycle competes only from the next one.
    always_comb begin
        claim_id    = claim_req ? best_id_q : '0;
        pending_out = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            gw_d[i]        = gw_q[i];
            pending_out[i] = (gw_q[i] == GW_PENDING);
            case (gw_q[i])
                GW_IDLE:     if (src_irq[i]) gw_d[i] = GW_PENDING;
                GW_PENDING:  if (claim_req && (best_id_q == ID_W'(i + 1))) gw_d[i] = GW_INFLIGHT;
                GW_INFLIGHT: if (complete_req && (complete_id == ID_W'(i + 1))) gw_d[i] = GW_IDLE;
                default:     gw_d[i] = GW_IDLE;
            endcase
        end
    end

    // Config changes only move eligibility; gateway states are left untouched.
    always_comb begin
        enable_d = enable_q;
        thr_d    = thr_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_d[i] = prio_q[i];
            if (cfg_we && (cfg_addr == AW'(i))) prio_d[i] = cfg_wdata[PRI_W-1:0];
        end
        if (cfg_we && (cfg_addr == AW'(NUM_SRC)))     enable_d = cfg_wdata;
        if (cfg_we && (cfg_addr == AW'(NUM_SRC + 1))) thr_d    = cfg_wdata[PRI_W-1:0];
    end

    // NOTE: the priority table is reset like any other flop because priority 0 must mean "silent" from power-up.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_q[i]   <= GW_IDLE;
                prio_q[i] <= '0;
            end
            enable_q  <= '0;
            thr_q     <= '0;
            best_id_q <= '0;
            meip_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_q[i]   <= gw_d[i];
                prio_q[i] <= prio_d[i];
            end
            enable_q  <= enable_d;
            thr_q     <= thr_d;
            best_id_q <= best_id_d;
            meip_q    <= meip_d;
        end
    end

    assign meip_out = meip_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized and directed bench for irq_arbiter, checked every cycle against a set-based reference model.
module tb_irq_arbiter;

    localparam int NUM_SRC = 8;
    localparam int PRI_W   = 3;
    localparam int ID_W    = 4;

    logic               clk_in = 1'b0;
    logic               reset_in;
    logic [NUM_SRC-1:0] src_irq;
    logic               cfg_we;
    logic [ID_W:0]      cfg_addr;
    logic [NUM_SRC-1:0] cfg_wdata;
    logic               claim_req;
    logic [ID_W-1:0]    claim_id;
    logic               complete_req;
    logic [ID_W-1:0]    complete_id;
    logic               meip_out;
    logic [NUM_SRC-1:0] pending_out;

    irq_arbiter #(.NUM_SRC(NUM_SRC), .PRI_W(PRI_W), .ID_W(ID_W)) dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .src_irq     (src_irq),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .claim_req   (claim_req),
        .claim_id    (claim_id),
        .complete_req(complete_req),
        .complete_id (complete_id),
        .meip_out    (meip_out),
        .pending_out (pending_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: which sources are waiting, which are being serviced, and the configuration.
    bit m_pend [NUM_SRC];
    bit m_infl [NUM_SRC];
    int m_prio [NUM_SRC];
    int m_en;
    int m_thr;
    int m_best;
    int m_meip;

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) begin
            m_pend[i] = 0;
            m_infl[i] = 0;
            m_prio[i] = 0;
        end
        m_en = 0; m_thr = 0; m_best = 0; m_meip = 0;
    endtask

    function automatic int model_select();
        int best = 0;
        int bp   = 0;
        for (int id = 1; id <= NUM_SRC; id++) begin
            if (m_pend[id-1] && ((m_en >> (id-1)) & 1) != 0 && m_prio[id-1] > m_thr && m_prio[id-1] > bp) begin
                bp   = m_prio[id-1];
                best = id;
            end
        end
        return best;
    endfunction

    function automatic int model_pending();
        int v = 0;
        for (int i = 0; i < NUM_SRC; i++) if (m_pend[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_edge();
        int nb = model_select();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (m_infl[i]) begin
                if (complete_req && int'(complete_id) == i + 1) m_infl[i] = 0;
            end else if (m_pend[i]) begin
                if (claim_req && m_best == i + 1) begin
                    m_pend[i] = 0;
                    m_infl[i] = 1;
                end
            end else if (src_irq[i]) begin
                m_pend[i] = 1;
            end
        end
        if (cfg_we) begin
            if (int'(cfg_addr) < NUM_SRC)           m_prio[cfg_addr] = int'(cfg_wdata) % 8;
            else if (int'(cfg_addr) == NUM_SRC)     m_en  = int'(cfg_wdata);
            else if (int'(cfg_addr) == NUM_SRC + 1) m_thr = int'(cfg_wdata) % 8;
        end
        m_best = nb;
        m_meip = (nb != 0) ? 1 : 0;
    endtask

    task automatic tick();
        @(negedge clk_in);
        check("claim_id", int'(claim_id), claim_req ? m_best : 0);
        check("meip_out", int'(meip_out), m_meip);
        check("pending_out", int'(pending_out), model_pending());
        @(posedge clk_in);
        model_edge();
        #1;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        cfg_we       = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = (ID_W+1)'(addr);
        cfg_wdata = NUM_SRC'(data);
        tick();
    endtask

    task automatic do_claim(input string tag, input int exp_id);
        claim_req = 1'b1;
        #1;
        check(tag, int'(claim_id), exp_id);
        tick();
    endtask

    task automatic do_complete(input int id);
        complete_req = 1'b1;
        complete_id  = ID_W'(id);
        tick();
    endtask

    initial begin
        reset_in     = 1'b0;
        src_irq      = '0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_wdata    = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;
        model_reset();
        #1;
        check("rst_meip", int'(meip_out), 0);
        check("rst_pending", int'(pending_out), 0);
        check("rst_claim", int'(claim_id), 0);
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b1;
        ticks(2);

        // 1: single source, two-cycle latency to meip_out, claim drops it two cycles on.
        cfg_write(2, 2);
        cfg_write(NUM_SRC, 8'h04);
        cfg_write(NUM_SRC + 1, 0);
        src_irq[2] = 1'b1;
        tick();
        check("t1_meip_early", int'(meip_out), 0);
        tick();
        check("t1_meip_set", int'(meip_out), 1);
        do_claim("t1_claim", 3);
        tick();
        check("t1_meip_clr", int'(meip_out), 0);
        src_irq[2] = 1'b0;
        do_complete(3);
        ticks(2);

        // 2: priority order with tie broken by lowest ID.
        cfg_write(1, 4);
        cfg_write(4, 4);
        cfg_write(6, 6);
        cfg_write(NUM_SRC, 8'h52);
        src_irq = 8'b0101_0010;
        tick();
        src_irq = '0;
        ticks(2);
        do_claim("t2_claim_a", 7);
        tick();
        do_claim("t2_claim_b", 2);
        tick();
        do_claim("t2_claim_c", 5);
        tick();
        do_claim("t2_claim_d", 0);
        do_complete(7);
        do_complete(2);
        do_complete(5);
        ticks(2);

        // 3: priority equal to threshold is masked; lowering the threshold unmasks it.
        cfg_write(NUM_SRC + 1, 4);
        cfg_write(0, 4);
        cfg_write(NUM_SRC, 8'h01);
        src_irq[0] = 1'b1;
        ticks(4);
        check("t3_meip_masked", int'(meip_out), 0);
        cfg_write(NUM_SRC + 1, 3);
        tick();
        check("t3_meip_unmasked", int'(meip_out), 1);
        src_irq[0] = 1'b0;
        do_claim("t3_claim", 1);
        do_complete(1);
        cfg_write(NUM_SRC + 1, 0);
        ticks(2);

        // 4: held line does not re-pend while in flight; re-pends after completion.
        cfg_write(3, 5);
        cfg_write(NUM_SRC, 8'h08);
        src_irq[3] = 1'b1;
        ticks(3);
        do_claim("t4_claim", 4);
        ticks(3);
        check("t4_meip_inflight", int'(meip_out), 0);
        check("t4_pending_inflight", int'(pending_out[3]), 0);
        do_complete(4);
        ticks(2);
        check("t4_meip_repend", int'(meip_out), 1);
        src_irq[3] = 1'b0;
        do_claim("t4_claim2", 4);
        do_complete(4);
        ticks(2);

        // 5: bogus completions are ignored; claim with nothing eligible returns 0.
        do_complete(6);
        do_complete(0);
        do_complete(9);
        check("t5_pending", int'(pending_out), 0);
        do_claim("t5_claim_none", 0);

        // 6: asynchronous reset mid-claim.
        cfg_write(1, 4);
        cfg_write(4, 4);
        cfg_write(6, 6);
        cfg_write(NUM_SRC, 8'h52);
        src_irq = 8'b0101_0010;
        ticks(3);
        claim_req = 1'b1;
        #1 reset_in = 1'b0;
        #1;
        check("t6_meip_async", int'(meip_out), 0);
        check("t6_pending_async", int'(pending_out), 0);
        check("t6_claim_async", int'(claim_id), 0);
        claim_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b1;
        ticks(3);
        check("t6_meip_prio_reset", int'(meip_out), 0);
        src_irq = '0;
        ticks(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_SRC; i++)
                if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
            if ($urandom_range(0, 7) == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = (ID_W+1)'($urandom_range(0, 11));
                if (int'(cfg_addr) == NUM_SRC + 1) cfg_wdata = NUM_SRC'($urandom_range(0, 4));
                else cfg_wdata = NUM_SRC'($urandom);
            end
            if ($urandom_range(0, 3) == 0) claim_req = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                complete_req = 1'b1;
                complete_id  = ID_W'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 0)
                    for (int i = 0; i < NUM_SRC; i++)
                        if (m_infl[i]) complete_id = ID_W'(i + 1);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
